// File: rtl/matrix_link.sv
// matrix_link: streams a 4x4 complex matrix from a local source buffer to a
// processing core, then collects the 16-element result into a result buffer.
// Optional feature: define MATRIX_LINK_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles with no returned beat (done and timeout pulse together).
module matrix_link #(
    parameter int BIT_NUM        = 18,
    parameter int CHANNEL_SIZE   = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ld_en,
    input  logic [3:0]         ld_addr,
    input  logic [BIT_NUM-1:0] ld_R,
    input  logic [BIT_NUM-1:0] ld_I,
    input  logic               start,
    output logic               busy,
    output logic               tx_valid,
    output logic [BIT_NUM-1:0] tx_R,
    output logic [BIT_NUM-1:0] tx_I,
    input  logic               rx_valid,
    input  logic [BIT_NUM-1:0] rx_R,
    input  logic [BIT_NUM-1:0] rx_I,
    input  logic [3:0]         rd_addr,
    output logic [BIT_NUM-1:0] rd_R,
    output logic [BIT_NUM-1:0] rd_I,
    output logic               done,
    output logic               timeout
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_CAPTURE,
        S_DONE
    } state_t;

    localparam logic [3:0] LAST_BEAT = 4'(CHANNEL_SIZE - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic       src_we;
    logic       res_we;

    logic [BIT_NUM-1:0] src_r [CHANNEL_SIZE];
    logic [BIT_NUM-1:0] src_i [CHANNEL_SIZE];
    logic [BIT_NUM-1:0] res_r [CHANNEL_SIZE];
    logic [BIT_NUM-1:0] res_i [CHANNEL_SIZE];

`ifdef MATRIX_LINK_TIMEOUT_EN
    localparam int WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
    logic              to_flag, to_flag_nx;
`endif

    // State, beat counter and (optional) wait counter / abort flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
`ifdef MATRIX_LINK_TIMEOUT_EN
            wait_cnt <= '0;
            to_flag  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state    <= state_nx;
            cnt      <= cnt_nx;
`ifdef MATRIX_LINK_TIMEOUT_EN
            wait_cnt <= wait_cnt_nx;
            to_flag  <= to_flag_nx;
`endif
        end
    end

    // Next-state, buffer write enables and transaction outputs.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statement can leave a latch behind.
        state_nx = state;
        cnt_nx   = cnt;
        src_we   = 1'b0;
        res_we   = 1'b0;
        busy     = (state != S_IDLE);
        tx_valid = 1'b0;
        tx_R     = '0;
        tx_I     = '0;
        done     = 1'b0;
        timeout  = 1'b0;
`ifdef MATRIX_LINK_TIMEOUT_EN
        wait_cnt_nx = wait_cnt;
        to_flag_nx  = to_flag;
`endif

        case (state)
            S_IDLE: begin
                // A load in the start cycle still lands before beat 0 is read.
                src_we = ld_en;
                if (start) begin
                    state_nx = S_SEND;
                    cnt_nx   = '0;
`ifdef MATRIX_LINK_TIMEOUT_EN
                    to_flag_nx = 1'b0;
`endif
                end
            end

            S_SEND: begin
                tx_valid = 1'b1;
                tx_R     = src_r[cnt];
                tx_I     = src_i[cnt];
                cnt_nx   = cnt + 4'd1;
                if (cnt == LAST_BEAT) begin
                    state_nx = S_WAIT;
                    cnt_nx   = '0;
`ifdef MATRIX_LINK_TIMEOUT_EN
                    wait_cnt_nx = '0;
`endif
                end
            end

            S_WAIT: begin
                if (rx_valid) begin
                    // cnt is 0 here, so the first returned beat lands in res[0].
                    res_we   = 1'b1;
                    state_nx = S_CAPTURE;
                    cnt_nx   = 4'd1;
                end
`ifdef MATRIX_LINK_TIMEOUT_EN
                else if (wait_cnt == WAIT_LAST) begin
                    state_nx   = S_DONE;
                    to_flag_nx = 1'b1;
                end else begin
                    wait_cnt_nx = wait_cnt + 1'b1;
                end
`endif
            end

            S_CAPTURE: begin
                // Idle rx cycles simply hold cnt, so gaps in the return stream are harmless.
                if (rx_valid) begin
                    res_we = 1'b1;
                    cnt_nx = cnt + 4'd1;
                    if (cnt == LAST_BEAT) begin
                        state_nx = S_DONE;
                    end
                end
            end

            S_DONE: begin
                done     = 1'b1;
`ifdef MATRIX_LINK_TIMEOUT_EN
                timeout    = to_flag;
                to_flag_nx = 1'b0;
`endif
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end

            default: begin
                state_nx = S_IDLE;
                cnt_nx   = '0;
            end
        endcase
    end

    // Source and result buffers; loaded only while idle / capturing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the buffers are cleared on reset because rd_R/rd_I must
            // read 0 afterwards; this keeps them in flops rather than RAM.
            for (int i = 0; i < CHANNEL_SIZE; i++) begin
                src_r[i] <= '0;
                src_i[i] <= '0;
                res_r[i] <= '0;
                res_i[i] <= '0;
            end
        end else begin
            if (src_we) begin
                src_r[ld_addr] <= ld_R;
                src_i[ld_addr] <= ld_I;
            end
            if (res_we) begin
                res_r[cnt] <= rx_R;
                res_i[cnt] <= rx_I;
            end
        end
    end

    // Result read port is combinational and available in every state.
    assign rd_R = res_r[rd_addr];
    assign rd_I = res_i[rd_addr];

endmodule

// File: tb/tb_matrix_link.sv
// Self-checking bench for matrix_link. A transaction-level model (beats sent,
// beats received, wait cycles) predicts every output on every falling edge;
// directed sections pin the model with hand-computed literals. Build with
// MATRIX_LINK_TIMEOUT_EN defined to exercise the abort path.
module tb_matrix_link;

    localparam int W   = 18;
    localparam int N   = 16;
    localparam int TO  = 64;
    localparam int DLY = 20;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ld_en;
    logic [3:0]   ld_addr;
    logic [W-1:0] ld_R, ld_I;
    logic         start;
    logic         busy;
    logic         tx_valid;
    logic [W-1:0] tx_R, tx_I;
    logic         rx_valid;
    logic [W-1:0] rx_R, rx_I;
    logic [3:0]   rd_addr;
    logic [W-1:0] rd_R, rd_I;
    logic         done;
    logic         timeout;

    matrix_link #(.BIT_NUM(W), .CHANNEL_SIZE(N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_R(ld_R), .ld_I(ld_I),
        .start(start), .busy(busy),
        .tx_valid(tx_valid), .tx_R(tx_R), .tx_I(tx_I),
        .rx_valid(rx_valid), .rx_R(rx_R), .rx_I(rx_I),
        .rd_addr(rd_addr), .rd_R(rd_R), .rd_I(rd_I),
        .done(done), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [W-1:0] wv(input int v);
        return v[W-1:0];
    endfunction

    // ---------------- behavioural model ----------------
    logic [W-1:0] m_src_r [N];
    logic [W-1:0] m_src_i [N];
    logic [W-1:0] m_res_r [N];
    logic [W-1:0] m_res_i [N];
    bit m_active, m_finish, m_to;
    int m_sent, m_got, m_wait;

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_src_r[i] = '0; m_src_i[i] = '0; m_res_r[i] = '0; m_res_i[i] = '0;
        end
        m_active = 0; m_finish = 0; m_to = 0;
        m_sent = 0; m_got = 0; m_wait = 0;
    endtask

    // One clock edge of the transaction: idle loads/start, 16 sends, waiting,
    // 16 receives, one done cycle.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (!m_active) begin
            if (ld_en) begin
                m_src_r[ld_addr] = ld_R;
                m_src_i[ld_addr] = ld_I;
            end
            if (start) begin
                m_active = 1; m_finish = 0; m_to = 0;
                m_sent = 0; m_got = 0; m_wait = 0;
            end
        end else if (m_finish) begin
            m_active = 0; m_finish = 0; m_to = 0;
        end else if (m_sent < N) begin
            m_sent++;
        end else if (rx_valid) begin
            m_res_r[m_got] = rx_R;
            m_res_i[m_got] = rx_I;
            m_got++;
            if (m_got == N) m_finish = 1;
        end else if (m_got == 0) begin
`ifdef MATRIX_LINK_TIMEOUT_EN
            m_wait++;
            if (m_wait == TO) begin
                m_finish = 1;
                m_to = 1;
            end
`endif
        end
    endtask

    // ---------------- driver ----------------
    int  cyc = 0;
    bit  rd_rand = 1;
    bit  loop_on = 0;
    int  loop_base = 0;
    bit  chk_on = 0;
    int  done_cnt = 0;
    logic [2*W:0] hist [64];

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        ld_en = 0; start = 0; rx_valid = 0; rx_R = '0; rx_I = '0;
        if (rd_rand) rd_addr = 4'($urandom);
        if (loop_on && (cyc - DLY) >= loop_base)
            {rx_valid, rx_R, rx_I} = hist[(cyc - DLY) % 64];
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step();
            n++;
        end
        check(name, done, 1'b1);
    endtask

    // ---------------- per-cycle comparison against the model ----------------
    bit           e_txv;
    logic [W-1:0] e_txr, e_txi;

    always @(negedge clk) begin
        hist[cyc % 64] = {tx_valid, tx_R, tx_I};
        if (chk_on) begin
            e_txv = m_active && !m_finish && (m_sent < N);
            e_txr = '0;
            e_txi = '0;
            if (e_txv) begin
                e_txr = m_src_r[m_sent];
                e_txi = m_src_i[m_sent];
            end
            check("busy", busy, m_active);
            check("tx_valid", tx_valid, e_txv);
            check("tx_R", tx_R, e_txr);
            check("tx_I", tx_I, e_txi);
            check("done", done, m_active && m_finish);
            check("timeout", timeout, m_active && m_finish && m_to);
            check("rd_R", rd_R, m_res_r[rd_addr]);
            check("rd_I", rd_I, m_res_i[rd_addr]);
            if (done === 1'b1) done_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int s_cyc;
    int dc0;

    initial begin
        rst_n = 0; ld_en = 0; ld_addr = '0; ld_R = '0; ld_I = '0; start = 0;
        rx_valid = 0; rx_R = '0; rx_I = '0; rd_addr = '0;
        model_reset();
        chk_on = 1;
        repeat (3) step();
        check("rst_busy", busy, 1'b0);
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_R", tx_R, '0);
        check("rst_done", done, 1'b0);
        check("rst_timeout", timeout, 1'b0);
        rst_n = 1;
        step();

        // Directed load (i, -i), loopback delayed DLY cycles.
        for (int i = 0; i < N; i++) begin
            ld_en = 1; ld_addr = 4'(i); ld_R = wv(i); ld_I = wv(-i);
            step();
        end
        loop_on = 1; loop_base = cyc;
        dc0 = done_cnt;
        start = 1; s_cyc = cyc;
        step();
        check("busy_after_start", busy, 1'b1);
        for (int k = 0; k < N; k++) begin
            check("beat_valid", tx_valid, 1'b1);
            check("beat_R", tx_R, wv(k));
            check("beat_I", tx_I, wv(-k));
            step();
        end
        check("tx_valid_after_16", tx_valid, 1'b0);
        wait_done(100, "loop_done_seen");
        // start in cycle s, beats s+1..s+16, rx beat k at s+21+k, done at s+37
        check("loop_latency", 64'(cyc - s_cyc), 64'd37);
        repeat (3) step();
        check("loop_done_once", 64'(done_cnt - dc0), 64'd1);
        loop_on = 0;
        rd_rand = 0; rd_addr = 4'd5; #1;
        check("rd5_R", rd_R, wv(5));
        check("rd5_I", rd_I, wv(-5));
        rd_rand = 1;

        // Randomized traffic: loads, starts, rx beats at any time.
        dc0 = done_cnt;
        for (int c = 0; c < 1500; c++) begin
            ld_en = ($urandom % 3) == 0; ld_addr = 4'($urandom);
            ld_R = W'($urandom); ld_I = W'($urandom);
            start = ($urandom % 12) == 0;
            rx_valid = ($urandom % 2) == 1; rx_R = W'($urandom); rx_I = W'($urandom);
            step();
        end
        for (int c = 0; c < 200 && busy === 1'b1; c++) begin
            rx_valid = 1; rx_R = W'($urandom); rx_I = W'($urandom);
            step();
        end
        check("rand_idle", busy, 1'b0);
        check("rand_txns", (done_cnt - dc0) >= 3, 1'b1);

        // Gapped return stream, junk during SEND and after completion.
        dc0 = done_cnt;
        start = 1;
        step();
        for (int k = 0; k < N; k++) begin
            rx_valid = 1; rx_R = wv(999); rx_I = wv(999);
            step();
        end
        repeat (2) step();
        for (int k = 0; k < N; k++) begin
            if (k == 8) repeat (3) step();
            rx_valid = 1; rx_R = wv(k); rx_I = wv(-k);
            step();
        end
        check("gap_done", done, 1'b1);
        for (int k = 0; k < 2; k++) begin
            rx_valid = 1; rx_R = wv(555); rx_I = wv(555);
            step();
        end
        check("gap_done_once", 64'(done_cnt - dc0), 64'd1);
        rd_rand = 0;
        for (int k = 0; k < N; k++) begin
            rd_addr = 4'(k); #1;
            check("gap_res_R", rd_R, wv(k));
            check("gap_res_I", rd_I, wv(-k));
        end
        rd_rand = 1;

`ifdef MATRIX_LINK_TIMEOUT_EN
        // No response: abort after TO wait cycles, result buffer untouched.
        start = 1; s_cyc = cyc;
        step();
        wait_done(200, "to_done_seen");
        check("to_pulse", timeout, 1'b1);
        // 1 start + 16 send + 64 wait cycles
        check("to_latency", 64'(cyc - s_cyc), 64'd81);
        step();
        check("to_idle_after", busy, 1'b0);
        rd_rand = 0; rd_addr = 4'd8; #1;
        check("to_res_kept", rd_R, wv(8));
        rd_rand = 1;
`else
        // No response and no timeout: the link waits forever.
        start = 1;
        step();
        repeat (200) step();
        check("no_to_busy", busy, 1'b1);
        check("no_to_timeout", timeout, 1'b0);
        #2 rst_n = 0; model_reset();
        step();
        rst_n = 1;
        step();
`endif

        // Load and start together, then reset during beat 6.
        ld_en = 1; ld_addr = 4'd0; ld_R = wv(100); ld_I = wv(77); start = 1;
        step();
        check("same_cycle_R", tx_R, wv(100));
        check("same_cycle_I", tx_I, wv(77));
        repeat (6) step();
        check("beat6_valid", tx_valid, 1'b1);
        dc0 = done_cnt;
        #2 rst_n = 0; model_reset();
        #1;
        check("abort_tx_valid", tx_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        rd_rand = 0;
        for (int k = 0; k < N; k++) begin
            rd_addr = 4'(k); #1;
            check("abort_rd_R", rd_R, '0);
            check("abort_rd_I", rd_I, '0);
        end
        rd_rand = 1;
        step();
        rst_n = 1;
        repeat (40) step();
        check("abort_no_done", 64'(done_cnt - dc0), 64'd0);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
